parity_tally_engine: RTL

PARITY_TALLY_ENGINE -- requirements
Module: parity_tally_engine

---
 rtl/parity_tally_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/parity_tally_engine.sv
// parity_tally_engine
// Small storage array that can be written while idle, then scanned over
// entries 0..len-1. Each scanned element is classified odd/even by bit 0,
// tallied, and offered on a ready/valid report port before the next one
// is read. abend_syndrome records how the last scan ended.
//
// Optional build macro: PARITY_TALLY_SUM_EN adds signed odd_sum/even_sum
// accumulators alongside the counts. With the macro undefined those
// ports and their logic are absent.
module parity_tally_engine #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    start,
  input  logic [CW-1:0]           len,
  output logic                    busy,
  output logic                    done,
  output logic [CW-1:0]           odd_count,
  output logic [CW-1:0]           even_count,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [AW-1:0]           rpt_index,
  output logic [WIDTH-1:0]        rpt_value,
`ifdef PARITY_TALLY_SUM_EN
  output logic signed [WIDTH+CW-1:0] odd_sum,
  output logic signed [WIDTH+CW-1:0] even_sum,
`endif
  output logic [7:0]              abend_syndrome
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [7:0]    ABEND_RUN_C     = 8'hFF;
  localparam logic [7:0]    ABEND_OK_C      = 8'h00;
  localparam logic [7:0]    ABEND_BAD_LEN_C = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Parity classification: bit 0 alone decides, so negative two's
  // complement values follow the same rule (-3 is odd).
  function automatic logic is_odd(input logic [WIDTH-1:0] value);
    return value[0];
  endfunction

`ifdef PARITY_TALLY_SUM_EN
  // Sign-extend an element to accumulator width.
  function automatic logic signed [WIDTH+CW-1:0] sext(input logic [WIDTH-1:0] value);
    return {{CW{value[WIDTH-1]}}, value};
  endfunction
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     odd_count_q, odd_count_d;
  logic [CW-1:0]     even_count_q, even_count_d;
  logic [AW-1:0]     rpt_index_q, rpt_index_d;
  logic [WIDTH-1:0]  rpt_value_q, rpt_value_d;
  logic [7:0]        abend_q, abend_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we_s;
  logic [WIDTH-1:0]  elem_s;
`ifdef PARITY_TALLY_SUM_EN
  logic signed [WIDTH+CW-1:0] odd_sum_q, odd_sum_d;
  logic signed [WIDTH+CW-1:0] even_sum_q, even_sum_d;
`endif

  // Element currently addressed by the scan index; idx < len <= DEPTH in SCAN.
  assign elem_s = mem_q[idx_q[AW-1:0]];

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    odd_count_d  = odd_count_q;
    even_count_d = even_count_q;
    rpt_index_d  = rpt_index_q;
    rpt_value_d  = rpt_value_q;
    abend_d      = abend_q;
    mem_we_s     = 1'b0;
`ifdef PARITY_TALLY_SUM_EN
    odd_sum_d    = odd_sum_q;
    even_sum_d   = even_sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        mem_we_s = wr_en;
        if (start) begin
          if (len > DEPTH_C) begin
            // Illegal length: finish immediately, counts untouched.
            state_d = ST_DONE;
            abend_d = ABEND_BAD_LEN_C;
          end else begin
            state_d = ST_INIT;
            abend_d = ABEND_RUN_C;
            idx_d   = ZERO_C;
            len_d   = len;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        odd_count_d  = ZERO_C;
        even_count_d = ZERO_C;
`ifdef PARITY_TALLY_SUM_EN
        odd_sum_d    = {(WIDTH+CW){1'b0}};
        even_sum_d   = {(WIDTH+CW){1'b0}};
`endif
        if (len_q != ZERO_C) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SCAN: begin
        if (is_odd(elem_s)) begin
          odd_count_d = odd_count_q + ONE_C;
`ifdef PARITY_TALLY_SUM_EN
          odd_sum_d   = odd_sum_q + sext(elem_s);
`endif
        end else begin
          even_count_d = even_count_q + ONE_C;
`ifdef PARITY_TALLY_SUM_EN
          even_sum_d   = even_sum_q + sext(elem_s);
`endif
        end
        rpt_index_d = idx_q[AW-1:0];
        rpt_value_d = elem_s;
        state_d     = ST_REPORT;
      end
      ST_REPORT: begin
        if (rpt_ready) begin
          idx_d = idx_q + ONE_C;
          if ((idx_q + ONE_C) < len_q) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_REPORT;
        end
      end
      ST_DONE: begin
        // Keep the illegal-length code; any other path ended normally.
        if (abend_q == ABEND_BAD_LEN_C) begin
          abend_d = ABEND_BAD_LEN_C;
        end else begin
          abend_d = ABEND_OK_C;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and report/count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= ZERO_C;
      len_q        <= ZERO_C;
      odd_count_q  <= ZERO_C;
      even_count_q <= ZERO_C;
      rpt_index_q  <= {AW{1'b0}};
      rpt_value_q  <= {WIDTH{1'b0}};
      abend_q      <= ABEND_RUN_C;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      odd_count_q  <= odd_count_d;
      even_count_q <= even_count_d;
      rpt_index_q  <= rpt_index_d;
      rpt_value_q  <= rpt_value_d;
      abend_q      <= abend_d;
    end
  end

`ifdef PARITY_TALLY_SUM_EN
  // Signed per-class accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      odd_sum_q  <= {(WIDTH+CW){1'b0}};
      even_sum_q <= {(WIDTH+CW){1'b0}};
    end else begin
      odd_sum_q  <= odd_sum_d;
      even_sum_q <= even_sum_d;
    end
  end

  assign odd_sum  = odd_sum_q;
  assign even_sum = even_sum_q;
`endif

  // Storage array: cleared by reset, written only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign rpt_valid      = (state_q == ST_REPORT);
  assign odd_count      = odd_count_q;
  assign even_count     = even_count_q;
  assign rpt_index      = rpt_index_q;
  assign rpt_value      = rpt_value_q;
  assign abend_syndrome = abend_q;

endmodule
